// File: rtl/icache_line_refill.sv
// I-cache miss refill engine: AHB-Lite wrapping read burst, critical word first,
// assembled into one cache line. Optional macro ICACHE_CRIT_WORD_FWD_EN adds cw_valid/cw_data.
module icache_line_refill #(
  parameter  int unsigned CACHE_LINE = 128,
  parameter  int unsigned CACHE_SIZE = 8192,
  localparam int unsigned BEATS      = CACHE_LINE / 32,
  localparam int unsigned OFF_W      = $clog2(BEATS),
  localparam int unsigned IDX_W      = $clog2(CACHE_SIZE * 8 / CACHE_LINE),
  localparam int unsigned TAG_W      = 30 - IDX_W - OFF_W
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  output logic [31:0]           HADDR,
  output logic [1:0]            HTRANS,
  output logic [2:0]            HBURST,
  output logic [2:0]            HSIZE,
  output logic                  HWRITE,
  input  logic                  HREADY,
  input  logic                  HRESP,
  input  logic [31:0]           HRDATA,
  output logic                  fill_valid,
  input  logic                  fill_ready,
  output logic [CACHE_LINE-1:0] fill_line,
  output logic [TAG_W-1:0]      fill_tag,
  output logic [IDX_W-1:0]      fill_index,
  output logic                  fill_err
`ifdef ICACHE_CRIT_WORD_FWD_EN
  ,
  output logic                  cw_valid,
  output logic [31:0]           cw_data
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_e;
  typedef enum logic [1:0] {HT_IDLE = 2'b00, HT_BUSY = 2'b01, HT_NONSEQ = 2'b10, HT_SEQ = 2'b11} htrans_e;

  localparam logic [2:0]     BURST    = (BEATS == 16) ? 3'b110 : (BEATS == 8) ? 3'b100 : 3'b010;
  localparam logic [OFF_W-1:0] OFF_ONE  = OFF_W'(1);
  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(BEATS - 1);
  localparam logic [OFF_W:0]   CNT_ONE  = (OFF_W + 1)'(1);
  localparam logic [OFF_W:0]   CNT_FULL = (OFF_W + 1)'(BEATS);

  state_e                state_q, state_d;
  htrans_e               htrans_q, htrans_d;
  logic [31:0]           haddr_q, haddr_d;
  logic [CACHE_LINE-1:0] line_q, line_d;
  logic [TAG_W-1:0]      tag_q, tag_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  err_q, err_d;
  logic [OFF_W-1:0]      start_q, start_d;
  logic [OFF_W-1:0]      data_cnt_q, data_cnt_d;
  logic [OFF_W:0]        addr_cnt_q, addr_cnt_d;
  logic [OFF_W-1:0]      slot;
  logic                  unused_bits;
`ifdef ICACHE_CRIT_WORD_FWD_EN
  logic                  beat0_cap;
  logic                  cw_valid_q;
  logic [31:0]           cw_data_q;
`endif

  assign unused_bits = ^req_addr[1:0];
  assign slot        = start_q + data_cnt_q;

  always_comb begin
    state_d    = state_q;
    htrans_d   = htrans_q;
    haddr_d    = haddr_q;
    line_d     = line_q;
    tag_d      = tag_q;
    idx_d      = idx_q;
    err_d      = err_q;
    start_d    = start_q;
    data_cnt_d = data_cnt_q;
    addr_cnt_d = addr_cnt_q;
`ifdef ICACHE_CRIT_WORD_FWD_EN
    beat0_cap  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          tag_d      = req_addr[31 -: TAG_W];
          idx_d      = req_addr[OFF_W + 2 +: IDX_W];
          start_d    = req_addr[OFF_W + 1:2];
          haddr_d    = {req_addr[31:2], 2'b00};
          htrans_d   = HT_NONSEQ;
          err_d      = 1'b0;
          data_cnt_d = '0;
          addr_cnt_d = CNT_ONE;
          state_d    = S_ADDR;
        end
      end
      S_ADDR: begin
        if (HREADY) begin
          haddr_d[OFF_W + 1:2] = haddr_q[OFF_W + 1:2] + OFF_ONE;
          htrans_d             = HT_SEQ;
          addr_cnt_d           = addr_cnt_q + CNT_ONE;
          state_d              = S_DATA;
        end
      end
      S_DATA: begin
        // First ERROR cycle cancels the pending address even while HREADY is low.
        if (HRESP) begin
          htrans_d = HT_IDLE;
          if (HREADY) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end else if (HREADY) begin
          for (int unsigned k = 0; k < BEATS; k++) begin
            if (slot == OFF_W'(k)) line_d[32 * k +: 32] = HRDATA;
          end
          data_cnt_d = data_cnt_q + OFF_ONE;
`ifdef ICACHE_CRIT_WORD_FWD_EN
          beat0_cap  = (data_cnt_q == '0);
`endif
          if (addr_cnt_q < CNT_FULL) begin
            haddr_d[OFF_W + 1:2] = haddr_q[OFF_W + 1:2] + OFF_ONE;
            htrans_d             = HT_SEQ;
            addr_cnt_d           = addr_cnt_q + CNT_ONE;
          end else begin
            htrans_d = HT_IDLE;
          end
          if (data_cnt_q == OFF_LAST) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (fill_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= S_IDLE;
      htrans_q   <= HT_IDLE;
      haddr_q    <= '0;
      line_q     <= '0;
      tag_q      <= '0;
      idx_q      <= '0;
      err_q      <= 1'b0;
      start_q    <= '0;
      data_cnt_q <= '0;
      addr_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      htrans_q   <= htrans_d;
      haddr_q    <= haddr_d;
      line_q     <= line_d;
      tag_q      <= tag_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      start_q    <= start_d;
      data_cnt_q <= data_cnt_d;
      addr_cnt_q <= addr_cnt_d;
    end
  end

`ifdef ICACHE_CRIT_WORD_FWD_EN
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cw_valid_q <= 1'b0;
      cw_data_q  <= '0;
    end else begin
      cw_valid_q <= beat0_cap;
      if (beat0_cap) cw_data_q <= HRDATA;
    end
  end

  assign cw_valid = cw_valid_q;
  assign cw_data  = cw_data_q;
`endif

  assign req_ready  = (state_q == S_IDLE);
  assign fill_valid = (state_q == S_DONE);
  assign HADDR      = haddr_q;
  assign HTRANS     = htrans_q;
  assign HBURST     = BURST;
  assign HSIZE      = 3'b010;
  assign HWRITE     = 1'b0;
  assign fill_line  = line_q;
  assign fill_tag   = tag_q;
  assign fill_index = idx_q;
  assign fill_err   = err_q;

endmodule

// File: tb/tb_icache_line_refill.sv
// Randomized bench for icache_line_refill: AHB slave model with wait states/errors,
// reference line model kept as an array of words indexed by slot.
module tb_icache_line_refill;
  localparam int unsigned LINE  = 128;
  localparam int unsigned CSIZE = 8192;
  localparam int unsigned BEATS = LINE / 32;
  localparam int unsigned OFF_W = $clog2(BEATS);
  localparam int unsigned IDX_W = $clog2(CSIZE * 8 / LINE);
  localparam int unsigned TAG_W = 30 - IDX_W - OFF_W;

  logic             HCLK = 1'b0;
  logic             HRESETn = 1'b0;
  logic             req_valid, req_ready;
  logic [31:0]      req_addr;
  logic [31:0]      HADDR;
  logic [1:0]       HTRANS;
  logic [2:0]       HBURST, HSIZE;
  logic             HWRITE, HREADY, HRESP;
  logic [31:0]      HRDATA;
  logic             fill_valid, fill_ready, fill_err;
  logic [LINE-1:0]  fill_line;
  logic [TAG_W-1:0] fill_tag;
  logic [IDX_W-1:0] fill_index;
`ifdef ICACHE_CRIT_WORD_FWD_EN
  logic             cw_valid;
  logic [31:0]      cw_data;
`endif

  int checks = 0;
  int failures = 0;
  logic [31:0] mline [BEATS];

  always #5 HCLK = ~HCLK;

  icache_line_refill #(.CACHE_LINE(LINE), .CACHE_SIZE(CSIZE)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .HADDR(HADDR), .HTRANS(HTRANS), .HBURST(HBURST), .HSIZE(HSIZE), .HWRITE(HWRITE),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_line(fill_line),
    .fill_tag(fill_tag), .fill_index(fill_index), .fill_err(fill_err)
`ifdef ICACHE_CRIT_WORD_FWD_EN
    , .cw_valid(cw_valid), .cw_data(cw_data)
`endif
  );

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] model_line();
    logic [511:0] r;
    r = '0;
    for (int k = 0; k < BEATS; k++) r[32 * k +: 32] = mline[k];
    return r;
  endfunction

  // One full miss: request, burst with slave behaviour, fill handshake after bp stall cycles.
  task automatic do_refill(input logic [31:0] a, input int err_beat, input int wait_pct,
                           input int wait_beat, input int bp);
    int unsigned base, s, exp_a;
    int n_addr, n_data, err_stage, wcnt, cyc;
    bit dph;
    logic [1:0] exp_tr;
    logic [511:0] exp_line;
`ifdef ICACHE_CRIT_WORD_FWD_EN
    bit cw_pend;
    logic [31:0] cw_word;
    cw_pend = 0;
    cw_word = '0;
`endif
    base = a & ~(BEATS * 4 - 1);
    s    = (a >> 2) % BEATS;
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1; req_addr = a; HREADY = 1; HRESP = 0;
    @(negedge HCLK);
    req_valid = 0;
    chk("req_ready_busy", req_ready, 0);
    n_addr = 0; n_data = 0; err_stage = 0; wcnt = 0; cyc = 0; dph = 0;
    while (!fill_valid && cyc < 400) begin
`ifdef ICACHE_CRIT_WORD_FWD_EN
      chk("cw_valid", cw_valid, cw_pend);
      if (cw_pend) chk("cw_data", cw_data, cw_word);
      cw_pend = 0;
`endif
      if (err_stage == 0) begin
        exp_tr = (n_addr == 0) ? 2'b10 : (n_addr < BEATS) ? 2'b11 : 2'b00;
        chk("htrans", HTRANS, exp_tr);
        if (exp_tr[1]) begin
          exp_a = base + ((s + n_addr) % BEATS) * 4;
          chk("haddr", HADDR, exp_a);
        end
      end else begin
        chk("htrans_err_idle", HTRANS, 2'b00);
      end
      HRDATA = $urandom;
      if (dph && err_stage == 0 && n_data == err_beat) begin
        HREADY = 0; HRESP = 1; err_stage = 1;
      end else if (err_stage == 1) begin
        HREADY = 1; HRESP = 1; err_stage = 2;
      end else if (dph && ((n_data == wait_beat && wcnt < 2) || $urandom_range(99) < wait_pct)) begin
        if (n_data == wait_beat) wcnt++;
        HREADY = 0; HRESP = 0;
      end else begin
        HREADY = 1; HRESP = 0;
        if (dph) begin
`ifdef ICACHE_CRIT_WORD_FWD_EN
          if (n_data == 0) begin cw_pend = 1; cw_word = HRDATA; end
`endif
          mline[(s + n_data) % BEATS] = HRDATA;
          n_data++;
        end
      end
      if (HREADY) begin
        dph = HTRANS[1] && err_stage == 0;
        if (dph) n_addr++;
      end
      @(negedge HCLK);
      cyc++;
    end
    HREADY = 1; HRESP = 0;
    chk("fill_valid_timeout", fill_valid, 1);
    exp_line = model_line();
    chk("fill_line", fill_line, exp_line);
    chk("fill_tag", fill_tag, a >> (IDX_W + OFF_W + 2));
    chk("fill_index", fill_index, (a >> (OFF_W + 2)) & ((1 << IDX_W) - 1));
    chk("fill_err", fill_err, err_beat < BEATS);
    chk("beats_taken", n_data, (err_beat < BEATS) ? err_beat : BEATS);
    chk("done_htrans", HTRANS, 2'b00);
    req_valid = 1; req_addr = $urandom;
    for (int i = 0; i < bp; i++) begin
      fill_ready = 0;
      @(negedge HCLK);
      chk("bp_valid", fill_valid, 1);
      chk("bp_ready", req_ready, 0);
      chk("bp_line", fill_line, exp_line);
    end
    fill_ready = 1;
    @(negedge HCLK);
    fill_ready = 0;
    chk("post_valid", fill_valid, 0);
    chk("post_ready", req_ready, 1);
    req_valid = 0;
  endtask

  initial begin
    int eb;
    req_valid = 0; req_addr = '0; fill_ready = 0; HREADY = 1; HRESP = 0; HRDATA = '0;
    for (int k = 0; k < BEATS; k++) mline[k] = '0;
    repeat (3) @(negedge HCLK);
    chk("rst_htrans", HTRANS, 2'b00);
    chk("rst_haddr", HADDR, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_fill_valid", fill_valid, 0);
    chk("rst_fill_err", fill_err, 0);
    chk("rst_fill_line", fill_line, 0);
    chk("rst_fill_tag", fill_tag, 0);
    chk("rst_fill_index", fill_index, 0);
    chk("hburst", HBURST, 3'b010);
    chk("hsize", HSIZE, 3'b010);
    chk("hwrite", HWRITE, 0);
    HRESETn = 1;
    @(negedge HCLK);

    do_refill(32'h0004_1238, 99, 0, -1, 0);
    chk("dir_tag", fill_tag, 32'h20);
    chk("dir_index", fill_index, 32'h123);
    do_refill(32'h0004_1238, 99, 0, 1, 0);
    do_refill(32'h0004_1238, 2, 0, -1, 0);
    do_refill(32'h0004_1238, 99, 0, -1, 3);

    // Reset in the middle of beat 2's data phase.
    req_valid = 1; req_addr = 32'h0004_1238; HREADY = 1;
    @(negedge HCLK);
    req_valid = 0;
    repeat (3) begin HRDATA = $urandom; @(negedge HCLK); end
    HREADY = 0;
    #2 HRESETn = 0;
    #1;
    chk("arst_htrans", HTRANS, 2'b00);
    chk("arst_fill_valid", fill_valid, 0);
    chk("arst_req_ready", req_ready, 1);
    chk("arst_fill_line", fill_line, 0);
    for (int k = 0; k < BEATS; k++) mline[k] = '0;
    @(negedge HCLK);
    HRESETn = 1; HREADY = 1;
    @(negedge HCLK);
    do_refill(32'h0004_1238, 99, 0, -1, 0);

    for (int t = 0; t < 40; t++) begin
      eb = ($urandom_range(4) == 0) ? int'($urandom_range(BEATS - 1)) : 99;
      do_refill($urandom, eb, 30, -1, int'($urandom_range(3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
